mem_stage_access: RTL and testbench
===================================

# mem_stage_access

Memory-stage access unit and MEM/WB register for the pipelined MIPS core. It consumes the EX/MEM register outputs and runs a req/ack transaction to data memory for loads and stores. While a transaction is in flight it stalls the upstream pipeline. It then registers the result for write-back. Non-memory instructions pass through in one cycle with no stall.

## Interface
- TIMEOUT_CYCLES, 64: maximum number of BUSY cycles without ack before the access is aborted. Range 2..255.

- clk  input  1  clock; everything updates on rising edge
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk
- control_m  input  3  [2]=reg_write, [1]=mem_to_reg (load), [0]=mem_write (store)
- alu_result_m  input  32  effective address, or ALU result for non-memory instructions
- mem_write_data_m  input  32  store data
- reg_write_addr_m  input  5  destination register
- stall_m  output  1  combinational; when 1, upstream stage registers hold (we=0)
- dmem_req  output  1  registered request to data memory
- dmem_we  output  1  registered; 1=store, 0=load
- dmem_addr  output  32  registered word address; bits [1:0] are always 0
- dmem_wdata  output  32  registered store data
- dmem_ack  input  1  memory completion; meaningful only while dmem_req=1
- dmem_rdata  input  32  load data; valid in the ack cycle
- control_w  output  2  [1]=reg_write, [0]=mem_to_reg
- read_data_w  output  32  captured load data
- alu_result_w  output  32  captured alu_result_m
- reg_write_addr_w  output  5  captured reg_write_addr_m
- err_misaligned  output  1  one-cycle registered pulse
- err_timeout  output  1  one-cycle registered pulse

## Operation
- access = control_m[1] | control_m[0]; aligned = (alu_result_m[1:0] == 0).
- FSM states:
  - IDLE → BUSY when access & aligned.
  - BUSY → IDLE on dmem_ack.
  - BUSY → IDLE on timeout, i.e. count == TIMEOUT_CYCLES-1 with no ack.
- On IDLE→BUSY: dmem_req<=1, dmem_we<=control_m[0], dmem_addr<=alu_result_m, dmem_wdata<=mem_write_data_m, count<=0.
- In BUSY: dmem_* held stable; count increments each cycle without ack.
- On leaving BUSY: dmem_req<=0.
- stall_m = (IDLE & access & aligned) | (BUSY & ~dmem_ack & ~timeout).
- The MEM/WB register loads every edge:
  - stall_m=1: bubble. control_w<=0; data fields hold.
  - stall_m=0: capture the control_m[2:1] bits into control_w, plus alu_result_m and reg_write_addr_m.
  - Load completing on ack: read_data_w<=dmem_rdata.
  - Store completing: read_data_w holds.
- Misaligned access (IDLE, access, ~aligned):
  - no bus transaction and no stall;
  - retires with control_w<=0;
  - err_misaligned<=1 for one cycle.
- Timeout: the instruction retires with control_w<=0, read_data_w<=0 and err_timeout<=1 for one cycle.
- Ack arriving in the same cycle the timeout would fire: the ack wins; normal completion, no error.
- dmem_ack while not BUSY is ignored.
- Reset (rst=0 at the edge), including mid-transaction, forces:
  - state IDLE, dmem_req=0, dmem_we=0;
  - dmem_addr and dmem_wdata = 0;
  - control_w=0, read_data_w=0, alu_result_w=0, reg_write_addr_w=0;
  - err flags=0, count=0.
  - An abandoned memory request is dropped without handshake.

## Timing
- Non-memory instruction: enters at cycle N; results appear on the *_w outputs after edge N+1. Zero stall.
- Load or store with ack in the first BUSY cycle:
  - cycle N: IDLE, stall_m=1;
  - cycle N+1: dmem_req=1, ack=1, stall_m=0;
  - after edge N+2: state IDLE, dmem_req=0, result on *_w.
  - Total: 2 cycles, one stall cycle.
- Ack after k BUSY cycles: stall lasts k cycles; total k+1.
- Timeout: dmem_req is high for exactly TIMEOUT_CYCLES cycles. stall_m drops in the last of those cycles.
- stall_m is combinational from state, control_m, alu_result_m[1:0] and dmem_ack. It has no path from dmem_rdata.
- Back-to-back accesses: dmem_req is low for at least one cycle between transactions (the IDLE cycle).

## Test plan
- Reset with rst=0 during a BUSY load → on the next cycle dmem_req=0, stall_m=0 and every output is 0; a later ack is ignored.
- ALU op: control_m=3'b100, alu_result_m=0x1234, reg_write_addr_m=5'd8 → one cycle later control_w=2'b10, alu_result_w=0x1234, reg_write_addr_w=8, and stall_m never asserts.
- Load: control_m=3'b110, addr=0x100, memory acks on its 3rd req cycle with rdata=0xCAFEF00D →
  - stall_m is high for 3 cycles;
  - dmem_req is high for 3 cycles;
  - afterwards read_data_w=0xCAFEF00D and control_w=2'b11.
- Store: control_m=3'b001, addr=0x200, data=0xA5A5A5A5 with immediate ack → dmem_we=1, dmem_addr=0x200, dmem_wdata=0xA5A5A5A5 for one cycle; control_w=0.
- Misaligned load at addr 0x102 → dmem_req stays 0, stall_m=0, err_misaligned pulses one cycle, control_w=0.
- Timeout with TIMEOUT_CYCLES=4 and no ack → dmem_req high for exactly 4 cycles, then err_timeout pulses and read_data_w=0. Repeat with ack in the 4th cycle → no error.

Source files
------------

// File: rtl/mem_stage_access.sv
// Memory-stage access unit plus MEM/WB pipeline register for the MIPS core.
// Runs a req/ack data-memory transaction for loads/stores and stalls upstream while it is in flight.
module mem_stage_access #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  control_m,
    input  logic [31:0] alu_result_m,
    input  logic [31:0] mem_write_data_m,
    input  logic [4:0]  reg_write_addr_m,
    output logic        stall_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [1:0]  control_w,
    output logic [31:0] read_data_w,
    output logic [31:0] alu_result_w,
    output logic [4:0]  reg_write_addr_w,
    output logic        err_misaligned,
    output logic        err_timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state;
    logic [7:0] count;

    logic access;
    logic aligned;
    logic start;
    logic misaligned;
    logic timeout;
    logic load_done;

    assign access     = control_m[1] | control_m[0];
    assign aligned    = (alu_result_m[1:0] == 2'b00);
    assign start      = (state == IDLE) & access & aligned;
    assign misaligned = (state == IDLE) & access & ~aligned;
    // An ack in the final budget cycle wins over the timeout.
    assign timeout    = (state == BUSY) & ~dmem_ack & (count == 8'(TIMEOUT_CYCLES - 1));
    assign load_done  = (state == BUSY) & dmem_ack & ~dmem_we;
    assign stall_m    = start | ((state == BUSY) & ~dmem_ack & ~timeout);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            count            <= 8'd0;
            dmem_req         <= 1'b0;
            dmem_we          <= 1'b0;
            dmem_addr        <= 32'd0;
            dmem_wdata       <= 32'd0;
            control_w        <= 2'b00;
            read_data_w      <= 32'd0;
            alu_result_w     <= 32'd0;
            reg_write_addr_w <= 5'd0;
            err_misaligned   <= 1'b0;
            err_timeout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= BUSY;
                        dmem_req   <= 1'b1;
                        dmem_we    <= control_m[0];
                        dmem_addr  <= alu_result_m;
                        dmem_wdata <= mem_write_data_m;
                        count      <= 8'd0;
                    end
                end
                BUSY: begin
                    if (dmem_ack || timeout) begin
                        state    <= IDLE;
                        dmem_req <= 1'b0;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            err_misaligned <= misaligned;
            err_timeout    <= timeout;

            // Stalled cycles retire a bubble; data fields keep their last value.
            if (stall_m) begin
                control_w <= 2'b00;
            end else begin
                alu_result_w     <= alu_result_m;
                reg_write_addr_w <= reg_write_addr_m;
                if (misaligned || timeout)
                    control_w <= 2'b00;
                else
                    control_w <= control_m[2:1];
                if (timeout)
                    read_data_w <= 32'd0;
                else if (load_done)
                    read_data_w <= dmem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed bench for mem_stage_access with TIMEOUT_CYCLES=4 and a hand-driven memory ack.
module tb_mem_stage_access;

    logic        clk;
    logic        rst;
    logic [2:0]  control_m;
    logic [31:0] alu_result_m;
    logic [31:0] mem_write_data_m;
    logic [4:0]  reg_write_addr_m;
    logic        stall_m;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [1:0]  control_w;
    logic [31:0] read_data_w;
    logic [31:0] alu_result_w;
    logic [4:0]  reg_write_addr_w;
    logic        err_misaligned;
    logic        err_timeout;

    int checks_made;
    int checks_failed;

    int          stall_cnt;
    int          req_cnt;
    logic        seen_we;
    logic [31:0] seen_addr;
    logic [31:0] seen_wdata;

    mem_stage_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .control_m        (control_m),
        .alu_result_m     (alu_result_m),
        .mem_write_data_m (mem_write_data_m),
        .reg_write_addr_m (reg_write_addr_m),
        .stall_m          (stall_m),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_ack         (dmem_ack),
        .dmem_rdata       (dmem_rdata),
        .control_w        (control_w),
        .read_data_w      (read_data_w),
        .alu_result_w     (alu_result_w),
        .reg_write_addr_w (reg_write_addr_w),
        .err_misaligned   (err_misaligned),
        .err_timeout      (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_made++;
        if (obs !== exp) begin
            checks_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction and runs it to retirement; the memory acks on
    // its ack_n-th request cycle (0 = never). Counts stall and request cycles.
    task automatic run_instr(input logic [2:0] ctl, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [4:0] wa,
                             input int ack_n, input logic [31:0] rdata);
        logic done;
        done             = 1'b0;
        stall_cnt        = 0;
        req_cnt          = 0;
        seen_we          = 1'b0;
        seen_addr        = 32'd0;
        seen_wdata       = 32'd0;
        control_m        = ctl;
        alu_result_m     = addr;
        mem_write_data_m = wdata;
        reg_write_addr_m = wa;
        for (int i = 0; i < 20; i++) begin
            dmem_ack   = (ack_n != 0) && dmem_req && (req_cnt + 1 == ack_n);
            dmem_rdata = rdata;
            #1;
            if (stall_m) stall_cnt++;
            if (dmem_req) begin
                if (req_cnt == 0) begin
                    seen_we    = dmem_we;
                    seen_addr  = dmem_addr;
                    seen_wdata = dmem_wdata;
                end
                req_cnt++;
            end
            done = !stall_m;
            step();
            dmem_ack   = 1'b0;
            dmem_rdata = 32'd0;
            if (done) begin
                control_m = 3'b000;
                break;
            end
        end
        if (!done) check("retire_bound", 32'd0, 32'd1);
    endtask

    initial begin
        checks_made      = 0;
        checks_failed    = 0;
        rst              = 1'b0;
        control_m        = 3'b000;
        alu_result_m     = 32'd0;
        mem_write_data_m = 32'd0;
        reg_write_addr_m = 5'd0;
        dmem_ack         = 1'b0;
        dmem_rdata       = 32'd0;
        step();
        step();
        check("rst_req", dmem_req, 0);
        check("rst_control_w", control_w, 0);
        check("rst_read_data_w", read_data_w, 0);
        check("rst_stall", stall_m, 0);

        // Reset in the middle of a busy load.
        rst          = 1'b1;
        control_m    = 3'b110;
        alu_result_m = 32'h100;
        step();
        step();
        check("busy_req_before_rst", dmem_req, 1);
        rst       = 1'b0;
        control_m = 3'b000;
        step();
        check("midrst_req", dmem_req, 0);
        check("midrst_stall", stall_m, 0);
        check("midrst_addr", dmem_addr, 0);
        check("midrst_alu_w", alu_result_w, 0);
        rst        = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        step();
        dmem_ack = 1'b0;
        check("stray_ack_req", dmem_req, 0);
        check("stray_ack_rdata_w", read_data_w, 0);
        check("stray_ack_ctl_w", control_w, 0);

        // ALU op passes straight through.
        run_instr(3'b100, 32'h1234, 32'd0, 5'd8, 0, 32'd0);
        check("alu_stall_cnt", stall_cnt, 0);
        check("alu_req_cnt", req_cnt, 0);
        check("alu_control_w", control_w, 2'b10);
        check("alu_result_w", alu_result_w, 32'h1234);
        check("alu_wa_w", reg_write_addr_w, 8);

        // Load acked on the third request cycle.
        run_instr(3'b110, 32'h100, 32'd0, 5'd3, 3, 32'hCAFEF00D);
        check("ld_stall_cnt", stall_cnt, 3);
        check("ld_req_cnt", req_cnt, 3);
        check("ld_we", seen_we, 0);
        check("ld_addr", seen_addr, 32'h100);
        check("ld_read_data_w", read_data_w, 32'hCAFEF00D);
        check("ld_control_w", control_w, 2'b11);
        check("ld_wa_w", reg_write_addr_w, 3);
        check("ld_req_dropped", dmem_req, 0);

        // Store with immediate ack; load data register must hold.
        run_instr(3'b001, 32'h200, 32'hA5A5A5A5, 5'd0, 1, 32'h55555555);
        check("st_stall_cnt", stall_cnt, 1);
        check("st_req_cnt", req_cnt, 1);
        check("st_we", seen_we, 1);
        check("st_addr", seen_addr, 32'h200);
        check("st_wdata", seen_wdata, 32'hA5A5A5A5);
        check("st_control_w", control_w, 0);
        check("st_read_data_hold", read_data_w, 32'hCAFEF00D);

        // Misaligned load.
        run_instr(3'b110, 32'h102, 32'd0, 5'd4, 0, 32'd0);
        check("mis_stall_cnt", stall_cnt, 0);
        check("mis_req_cnt", req_cnt, 0);
        check("mis_err", err_misaligned, 1);
        check("mis_control_w", control_w, 0);
        step();
        check("mis_err_pulse", err_misaligned, 0);

        // Timeout with no ack.
        run_instr(3'b110, 32'h300, 32'd0, 5'd5, 0, 32'd0);
        check("to_req_cnt", req_cnt, 4);
        check("to_stall_cnt", stall_cnt, 4);
        check("to_err", err_timeout, 1);
        check("to_read_data_w", read_data_w, 0);
        check("to_control_w", control_w, 0);
        check("to_req_dropped", dmem_req, 0);
        step();
        check("to_err_pulse", err_timeout, 0);

        // Ack in the last budget cycle beats the timeout.
        run_instr(3'b110, 32'h304, 32'd0, 5'd6, 4, 32'h11112222);
        check("late_req_cnt", req_cnt, 4);
        check("late_stall_cnt", stall_cnt, 4);
        check("late_err", err_timeout, 0);
        check("late_read_data_w", read_data_w, 32'h11112222);
        check("late_control_w", control_w, 2'b11);

        $display("Simulation finished: %0d checks, %0d errors", checks_made, checks_failed);
        $finish;
    end

endmodule
